age_issue_picker: RTL and testbench
===================================

# age_issue_picker

Parametrised, stateful oldest-first issue selector for the integer issue queue. It owns per-entry valid bits and saturating age counters. Each cycle it picks up to PICK ready entries, oldest first, and registers them as grants. Granted entries are deallocated at the same edge, with stall and flush support. It sits between rename/dispatch (allocation) and the integer execution ports (grant consumers).

## Interface
- DEPTH, 8: number of queue entries; power of two, 2..32.
- PICK, 2: grants per cycle; 1..4, PICK <= DEPTH.
- AGE_W, 4: age counter width; ages saturate at 2^AGE_W-1.
- IDX_W, $clog2(DEPTH): entry index width (derived).

Clock and reset: one clock; reset is asynchronous and active-low.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  allocate the entry given by alloc_idx this cycle.
- alloc_idx  in  IDX_W  entry to allocate.
- entry_ready  in  DEPTH  per-entry operands-ready bit; sampled only for valid entries.
- stall  in  1  downstream cannot accept grants; freeze picking.
- flush  in  1  synchronous squash of all entries and grants.
- grant_valid  out  PICK  registered; contiguous from bit 0.
- grant_idx  out  PICK x IDX_W  registered; slot 0 is the oldest.
- entry_valid  out  DEPTH  current occupancy bitmap.
- count  out  IDX_W+1  number of valid entries.
- full  out  1  count == DEPTH.
- alloc_err  out  1  registered one-cycle pulse: allocation targeted an occupied entry.

## Operation

**Age bookkeeping**
- On an accepted allocation, the target entry gets valid=1 and age=0.
- In the same cycle, every other valid entry that is not being deallocated increments its age by 1.
- Ages saturate at 2^AGE_W-1 and never wrap.
- Larger age means older.

**Candidate set**
- An entry is a candidate when it is valid, entry_ready=1, and stall=0.
- An entry allocated this cycle is never a candidate this cycle.

**Selection**
- Pick up to PICK candidates in descending age order.
- Age ties go to the higher index.
- Slot k receives the k-th oldest candidate.
- If there are fewer candidates than PICK, the unused slots have grant_valid=0 and grant_idx=0.

**Deallocation**
- Each picked entry is cleared (valid=0, age=0) at the same edge that loads the grant registers.

**Stall**
- grant_valid and grant_idx hold their values.
- No picking and no deallocation occur.
- Allocation and age updates still proceed.

**Flush**
- Has priority over everything else.
- At the next edge: all valid=0, all ages=0, grant_valid=0, count=0. An allocation in the flush cycle is dropped.
- alloc_err is not raised for an allocation dropped by flush.

**Allocation to an occupied entry**
- The allocation is ignored: the entry's age is unchanged and other entries' ages are not incremented.
- alloc_err pulses to 1 for exactly one cycle.
- An entry being deallocated in the same cycle still counts as occupied.

**count / full**
- Updated each edge as count + accepted allocations - grants issued.

## Timing
- Reset (async assert): grant_valid=0, grant_idx=0, entry_valid=0, all ages 0, count=0, full=0, alloc_err=0. Outputs take these values immediately, independent of clk.
- Reset deassertion is synchronised externally; the first active edge after release behaves as a normal cycle.
- Allocation latency: alloc in cycle t → entry_valid visible in t+1; earliest grant in t+2.
- Pick latency: candidate at cycle t → grant_valid/grant_idx in t+1, with the entry cleared in t+1.
- Back-to-back picks are allowed every cycle, with a throughput of PICK per cycle.
- Grant outputs come directly from flops.
- entry_valid, count and full come directly from state flops.
- The selection logic is a purely combinational tree feeding the grant flops. It must close timing for DEPTH=32, PICK=4 in one cycle.

## Test plan
Default configuration for all scenarios: DEPTH=8, PICK=2, AGE_W=4.

1. **Oldest-first order.** Allocate 3, 5, 1 in cycles 0-2 with entry_ready=0; raise entry_ready=0xFF in cycle 3.
   - Cycle 4: grant_valid=2'b11, grant_idx={5,3}, i.e. slot0=3, slot1=5.
   - Cycle 5: grant_valid=2'b01, slot0=1.
   - Cycle 6: count=0.
2. **Saturation and tie-break.** Allocate 2, then 6, both with ready=0. Churn 16 allocate/grant pairs through entries 0/1.
   - Both ages read 15.
   - With ready on 2 and 6: slot0=6, slot1=2.
3. **Stall hold.** With grant_valid=2'b11 (idx 4, 7), hold stall=1 for 3 cycles while entry 0 becomes ready.
   - Grants hold 4/7 for all 3 cycles; count is unchanged; entry 0 is not picked until stall drops.
4. **Flush with allocation.** Fill all 8 entries (full=1), then assert flush and alloc_valid (idx 2) in the same cycle.
   - Next cycle: entry_valid=0, count=0, full=0, grant_valid=0, alloc_err=0.
5. **Occupied allocation.** Allocate 4 twice, one cycle apart.
   - alloc_err=1 for one cycle; entry 4's age is 0, not reset again.
   - count=1.
6. **Reset mid-operation.** With 5 valid entries and active grants, pulse reset_n low between clock edges.
   - All outputs read 0 before the next edge; normal allocation works after release.

Source files
------------

// File: rtl/age_issue_picker.sv
// rtl/age_issue_picker.sv - oldest-first issue selector with per-entry saturating ages.
// Picks up to PICK ready entries per cycle into grant flops and frees them at the same edge.
module age_issue_picker #(
   parameter  int DEPTH = 8,
   parameter  int PICK  = 2,
   parameter  int AGE_W = 4,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  alloc_valid,
   input  logic [IDX_W-1:0]      alloc_idx,
   input  logic [DEPTH-1:0]      entry_ready,
   input  logic                  stall,
   input  logic                  flush,
   output logic [PICK-1:0]       grant_valid,
   output logic [PICK*IDX_W-1:0] grant_idx,
   output logic [DEPTH-1:0]      entry_valid,
   output logic [IDX_W:0]        count,
   output logic                  full,
   output logic                  alloc_err
);

   localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
   localparam logic [IDX_W:0]   RANK_ONE = {{IDX_W{1'b0}}, 1'b1};

   logic [DEPTH-1:0]      r_valid;
   logic [AGE_W-1:0]      r_age [DEPTH];
   logic [PICK-1:0]       r_gv;
   logic [PICK*IDX_W-1:0] r_gi;
   logic [IDX_W:0]        r_count;
   logic                  r_full;
   logic                  r_err;

   logic [DEPTH-1:0]      w_cand;
   logic [IDX_W:0]        w_rank [DEPTH];
   logic [DEPTH-1:0]      w_dealloc;
   logic [PICK-1:0]       w_pick_valid;
   logic [PICK*IDX_W-1:0] w_pick_idx;
   logic [IDX_W:0]        w_ngrant;
   logic                  w_occupied;
   logic                  w_alloc_ok;
   logic [IDX_W:0]        w_count_nxt;

   assign w_cand     = r_valid & entry_ready & {DEPTH{~stall}};
   assign w_occupied = r_valid[alloc_idx];
   assign w_alloc_ok = alloc_valid & ~w_occupied;

   // Rank = number of candidates that beat this one (older, or same age with higher index).
   // All comparisons run in parallel, so depth is one compare plus a popcount.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_rank[i] = '0;
         for (int j = 0; j < DEPTH; j++) begin
            if (j != i && w_cand[j] &&
                ((r_age[j] > r_age[i]) || ((r_age[j] == r_age[i]) && (j > i))))
               w_rank[i] = w_rank[i] + RANK_ONE;
         end
      end
   end

   always_comb begin
      w_dealloc    = '0;
      w_pick_valid = '0;
      w_pick_idx   = '0;
      w_ngrant     = '0;
      for (int i = 0; i < DEPTH; i++)
         w_dealloc[i] = w_cand[i] && (w_rank[i] < (IDX_W+1)'(PICK));
      for (int k = 0; k < PICK; k++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_cand[i] && (w_rank[i] == (IDX_W+1)'(k))) begin
               w_pick_valid[k]                 = 1'b1;
               w_pick_idx[k*IDX_W +: IDX_W]    = w_pick_idx[k*IDX_W +: IDX_W] | IDX_W'(i);
            end
         end
         if (w_pick_valid[k])
            w_ngrant = w_ngrant + RANK_ONE;
      end
   end

   assign w_count_nxt = r_count + (IDX_W+1)'(w_alloc_ok) - w_ngrant;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
         r_gv    <= '0;
         r_gi    <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_err   <= 1'b0;
      end else if (flush) begin
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
         r_gv    <= '0;
         r_gi    <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_dealloc[i]) begin
               r_valid[i] <= 1'b0;
               r_age[i]   <= '0;
            end else if (w_alloc_ok && (IDX_W'(i) == alloc_idx)) begin
               r_valid[i] <= 1'b1;
               r_age[i]   <= '0;
            end else if (w_alloc_ok && r_valid[i] && (r_age[i] != AGE_MAX)) begin
               r_age[i]   <= r_age[i] + 1'b1;
            end
         end
         // Under stall w_dealloc is empty, so only the grant flops need an explicit hold.
         if (!stall) begin
            r_gv <= w_pick_valid;
            r_gi <= w_pick_idx;
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == (IDX_W+1)'(DEPTH));
         r_err   <= alloc_valid & w_occupied;
      end
   end

   assign grant_valid = r_gv;
   assign grant_idx   = r_gi;
   assign entry_valid = r_valid;
   assign count       = r_count;
   assign full        = r_full;
   assign alloc_err   = r_err;

endmodule

// File: tb/tb_age_issue_picker.sv
// tb/tb_age_issue_picker.sv - scoreboard bench for age_issue_picker (DEPTH=8, PICK=2, AGE_W=4).
module tb_age_issue_picker;

   localparam int DEPTH = 8;
   localparam int PICK  = 2;
   localparam int AGE_W = 4;
   localparam int IDX_W = 3;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic                  alloc_valid;
   logic [IDX_W-1:0]      alloc_idx;
   logic [DEPTH-1:0]      entry_ready;
   logic                  stall;
   logic                  flush;
   logic [PICK-1:0]       grant_valid;
   logic [PICK*IDX_W-1:0] grant_idx;
   logic [DEPTH-1:0]      entry_valid;
   logic [IDX_W:0]        count;
   logic                  full;
   logic                  alloc_err;

   age_issue_picker #(.DEPTH(DEPTH), .PICK(PICK), .AGE_W(AGE_W)) dut (
      .clk(clk), .reset_n(reset_n), .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
      .entry_ready(entry_ready), .stall(stall), .flush(flush), .grant_valid(grant_valid),
      .grant_idx(grant_idx), .entry_valid(entry_valid), .count(count), .full(full),
      .alloc_err(alloc_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PICK-1:0]       gv;
      logic [PICK*IDX_W-1:0] gi;
      logic [DEPTH-1:0]      ev;
      logic [IDX_W:0]        cnt;
      logic                  full;
      logic                  err;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;

   logic [DEPTH-1:0]      m_valid;
   int                    m_age [DEPTH];
   logic [PICK-1:0]       m_gv;
   logic [PICK*IDX_W-1:0] m_gi;
   logic                  m_err;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_valid = '0;
      for (int i = 0; i < DEPTH; i++) m_age[i] = 0;
      m_gv  = '0;
      m_gi  = '0;
      m_err = 1'b0;
   endtask

   // Reference: repeated oldest-first search, scanning high index down so ties favour the higher index.
   task automatic model_step();
      exp_t             e;
      logic [DEPTH-1:0] taken;
      bit               occ;
      bit               acc;
      int               best;
      int               cnt;
      taken = '0;
      if (flush) begin
         model_reset();
      end else begin
         occ   = m_valid[alloc_idx];
         acc   = alloc_valid && !occ;
         m_err = alloc_valid && occ;
         if (!stall) begin
            m_gv = '0;
            m_gi = '0;
            for (int k = 0; k < PICK; k++) begin
               best = -1;
               for (int i = DEPTH-1; i >= 0; i--)
                  if (m_valid[i] && entry_ready[i] && !taken[i] && (best < 0 || m_age[i] > m_age[best]))
                     best = i;
               if (best >= 0) begin
                  taken[best]            = 1'b1;
                  m_gv[k]                = 1'b1;
                  m_gi[k*IDX_W +: IDX_W] = IDX_W'(best);
               end
            end
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (taken[i]) begin
               m_valid[i] = 1'b0;
               m_age[i]   = 0;
            end else if (acc && i == int'(alloc_idx)) begin
               m_valid[i] = 1'b1;
               m_age[i]   = 0;
            end else if (acc && m_valid[i] && m_age[i] < (1 << AGE_W) - 1) begin
               m_age[i]   = m_age[i] + 1;
            end
         end
      end
      cnt    = $countones(m_valid);
      e.gv   = m_gv;
      e.gi   = m_gi;
      e.ev   = m_valid;
      e.cnt  = (IDX_W+1)'(cnt);
      e.full = (cnt == DEPTH);
      e.err  = m_err;
      sb.push_back(e);
   endtask

   task automatic tick(input bit av, input int ai, input logic [DEPTH-1:0] rdy,
                       input bit st = 1'b0, input bit fl = 1'b0);
      exp_t e;
      alloc_valid = av;
      alloc_idx   = IDX_W'(ai);
      entry_ready = rdy;
      stall       = st;
      flush       = fl;
      model_step();
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check_eq("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check_eq("grant_valid", grant_valid, e.gv);
         check_eq("grant_idx",   grant_idx,   e.gi);
         check_eq("entry_valid", entry_valid, e.ev);
         check_eq("count",       count,       e.cnt);
         check_eq("full",        full,        e.full);
         check_eq("alloc_err",   alloc_err,   e.err);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_gv"},  grant_valid, 0);
      check_eq({tag, "_gi"},  grant_idx,   0);
      check_eq({tag, "_ev"},  entry_valid, 0);
      check_eq({tag, "_cnt"}, count,       0);
      check_eq({tag, "_full"}, full,       0);
      check_eq({tag, "_err"}, alloc_err,   0);
   endtask

   initial begin
      reset_n     = 1'b0;
      alloc_valid = 1'b0;
      alloc_idx   = '0;
      entry_ready = '0;
      stall       = 1'b0;
      flush       = 1'b0;
      model_reset();
      #3;
      check_all_zero("reset");
      #9;
      reset_n = 1'b1;

      // Oldest-first order
      tick(1, 3, 8'h00);
      tick(1, 5, 8'h00);
      tick(1, 1, 8'h00);
      tick(0, 0, 8'hFF);
      check_eq("t1_gv0", grant_valid, 2'b11);
      check_eq("t1_gi0", grant_idx, {3'd5, 3'd3});
      tick(0, 0, 8'hFF);
      check_eq("t1_gv1", grant_valid, 2'b01);
      check_eq("t1_gi1", grant_idx, {3'd0, 3'd1});
      tick(0, 0, 8'hFF);
      check_eq("t1_cnt", count, 0);

      // Saturation and tie-break
      tick(1, 2, 8'h00);
      tick(1, 6, 8'h00);
      for (int n = 0; n < 16; n++) tick(1, n % 2, 8'h03);
      tick(0, 0, 8'h44);
      check_eq("t2_gv", grant_valid, 2'b11);
      check_eq("t2_gi", grant_idx, {3'd2, 3'd6});
      tick(0, 0, 8'h02);
      tick(0, 0, 8'h00);
      check_eq("t2_cnt", count, 0);

      // Stall hold
      tick(1, 4, 8'h00);
      tick(1, 7, 8'h00);
      tick(1, 0, 8'h00);
      tick(0, 0, 8'h90);
      for (int n = 0; n < 3; n++) begin
         tick(0, 0, 8'h01, 1'b1);
         check_eq("t3_gv", grant_valid, 2'b11);
         check_eq("t3_gi", grant_idx, {3'd7, 3'd4});
         check_eq("t3_cnt", count, 1);
      end
      tick(0, 0, 8'h01);
      check_eq("t3_gv_rel", grant_valid, 2'b01);
      check_eq("t3_gi_rel", grant_idx, {3'd0, 3'd0});

      // Flush with allocation
      for (int i = 0; i < DEPTH; i++) tick(1, i, 8'h00);
      check_eq("t4_full", full, 1);
      tick(1, 2, 8'h00, 1'b0, 1'b1);
      check_all_zero("t4_flush");

      // Occupied allocation
      tick(1, 4, 8'h00);
      tick(1, 4, 8'h00);
      check_eq("t5_err", alloc_err, 1);
      check_eq("t5_cnt", count, 1);
      tick(0, 0, 8'h00);
      check_eq("t5_err_drop", alloc_err, 0);
      tick(0, 0, 8'h10);

      // Reset mid-operation
      for (int i = 0; i < 5; i++) tick(1, i, 8'h00);
      tick(0, 0, 8'h03);
      check_eq("t6_gv", grant_valid, 2'b11);
      reset_n = 1'b0;
      #2;
      check_all_zero("t6_reset");
      model_reset();
      sb.delete();
      #1;
      reset_n = 1'b1;
      tick(1, 3, 8'h00);
      check_eq("t6_ev", entry_valid, 8'h08);
      tick(0, 0, 8'h08);

      // Random traffic against the reference model
      for (int n = 0; n < 400; n++)
         tick($urandom_range(0, 1), $urandom_range(0, DEPTH-1), DEPTH'($urandom),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
